bram_read_arbiter: RTL and testbench

//  Shares the single-port sprite/tile BRAM read port between the VGA pixel-address path
//  (priority requester) and an auxiliary requester, e.g. a collision sampler that reads

---
 rtl/bram_read_arbiter.sv | 131 +++++++++++++
 tb/tb_bram_read_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_arbiter.sv
// Read-port arbiter for the sprite/tile BRAM: video addresses pass with one register
// stage, an auxiliary requester gets one outstanding read at a time plus statistics.
module bram_read_arbiter #(
    parameter int AW         = 17,
    parameter int DW         = 12,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 1024,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          aux_req,
    input  logic [AW-1:0] aux_addr,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_dout,
    input  logic          clr_stats,
    output logic          aux_starve,
    output logic [CW-1:0] aux_gnt_cnt
);

    localparam int WCW = $clog2(STARVE_MAX + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_MAX);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

    logic [0:0]        state_r;
    logic [RD_LAT-1:0] tag_aux_r;
    logic [RD_LAT-1:0] tag_nxt_s;
    logic [WCW-1:0]    wait_cnt_r;
    logic [WCW-1:0]    wait_nxt_s;
    logic              grant_s;
    logic              ret_s;
    logic              aux_gnt_r;
    logic              aux_rvalid_r;
    logic [DW-1:0]     aux_rdata_r;
    logic [AW-1:0]     bram_addr_r;
    logic              aux_starve_r;
    logic [CW-1:0]     aux_gnt_cnt_r;

    // Grant decision and tag pipe advance; only the AUX tag matters downstream.
    always_comb begin
        grant_s   = (!vid_req) && (state_r == ST_IDLE) && aux_req;
        ret_s     = tag_aux_r[RD_LAT-1];
        tag_nxt_s = (tag_aux_r << 1) | RD_LAT'(grant_s);
    end

    // Starvation counter: counts idle cycles spent blocked by video, saturating.
    always_comb begin
        wait_nxt_s = wait_cnt_r;
        if (grant_s) begin
            wait_nxt_s = {WCW{1'b0}};
        end else if (aux_req && (state_r == ST_IDLE) && (wait_cnt_r != WAIT_MAX)) begin
            wait_nxt_s = wait_cnt_r + 1'b1;
        end else begin
            wait_nxt_s = wait_cnt_r;
        end
    end

    // Address mux, handshake outputs and the one-outstanding-read FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            tag_aux_r    <= {RD_LAT{1'b0}};
            bram_addr_r  <= {AW{1'b0}};
            aux_gnt_r    <= 1'b0;
            aux_rvalid_r <= 1'b0;
            aux_rdata_r  <= {DW{1'b0}};
        end else begin
            tag_aux_r    <= tag_nxt_s;
            aux_gnt_r    <= grant_s;
            aux_rvalid_r <= ret_s;
            if (vid_req) begin
                bram_addr_r <= vid_addr;
            end else if (grant_s) begin
                bram_addr_r <= aux_addr;
            end else begin
                bram_addr_r <= bram_addr_r;
            end
            if (ret_s) begin
                aux_rdata_r <= bram_dout;
            end else begin
                aux_rdata_r <= aux_rdata_r;
            end
            case (state_r)
                ST_IDLE: state_r <= grant_s ? ST_WAIT : ST_IDLE;
                ST_WAIT: state_r <= ret_s ? ST_IDLE : ST_WAIT;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Statistics: clr_stats takes precedence over a same-cycle grant or starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r    <= {WCW{1'b0}};
            aux_starve_r  <= 1'b0;
            aux_gnt_cnt_r <= {CW{1'b0}};
        end else begin
            wait_cnt_r <= wait_nxt_s;
            if (clr_stats) begin
                aux_starve_r  <= 1'b0;
                aux_gnt_cnt_r <= {CW{1'b0}};
            end else begin
                if (wait_nxt_s == WAIT_MAX) begin
                    aux_starve_r <= 1'b1;
                end else begin
                    aux_starve_r <= aux_starve_r;
                end
                if (grant_s && (aux_gnt_cnt_r != CNT_MAX)) begin
                    aux_gnt_cnt_r <= aux_gnt_cnt_r + 1'b1;
                end else begin
                    aux_gnt_cnt_r <= aux_gnt_cnt_r;
                end
            end
        end
    end

    assign aux_gnt     = aux_gnt_r;
    assign aux_rvalid  = aux_rvalid_r;
    assign aux_rdata   = aux_rdata_r;
    assign bram_addr   = bram_addr_r;
    assign aux_starve  = aux_starve_r;
    assign aux_gnt_cnt = aux_gnt_cnt_r;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: directed scenarios plus random traffic, all checked each
// cycle against a transaction-level model of the arbiter and a behavioural BRAM.
module tb_bram_read_arbiter;

    localparam int AW         = 17;
    localparam int DW         = 12;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 1024;
    localparam int CW         = 8;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          aux_req = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic          aux_gnt;
    logic          aux_rvalid;
    logic [DW-1:0] aux_rdata;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic          clr_stats = 1'b0;
    logic          aux_starve;
    logic [CW-1:0] aux_gnt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bram_read_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .vid_req(vid_req), .vid_addr(vid_addr),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
        .aux_rdata(aux_rdata), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .clr_stats(clr_stats), .aux_starve(aux_starve), .aux_gnt_cnt(aux_gnt_cnt)
    );

    always #20 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        int v;
        v = int'(a) * 3 + 32'h5A5;
        return v[DW-1:0];
    endfunction

    // Behavioural BRAM: dout reflects the address registered RD_LAT-1 edges earlier.
    logic [AW-1:0] rd_pipe [RD_LAT-1];
    always_ff @(posedge clk) begin
        rd_pipe[0] <= bram_addr;
        for (int i = 1; i < RD_LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = mem_word(rd_pipe[RD_LAT-2]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the arbiter.
    logic          exp_gnt = 1'b0, exp_rvalid = 1'b0, exp_starve = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [CW-1:0] exp_cnt = '0;
    bit            m_busy = 1'b0;
    int            m_ret = 0;
    int            m_waited = 0;
    logic [AW-1:0] m_pend = '0;

    initial begin
        bit was_idle;
        bit grant;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_gnt = 1'b0; exp_rvalid = 1'b0; exp_starve = 1'b0;
                exp_rdata = '0; exp_addr = '0; exp_cnt = '0;
                m_busy = 1'b0; m_ret = 0; m_waited = 0;
            end else begin
                was_idle   = !m_busy;
                exp_rvalid = 1'b0;
                if (m_busy) begin
                    m_ret = m_ret - 1;
                    if (m_ret == 0) begin
                        exp_rvalid = 1'b1;
                        exp_rdata  = mem_word(m_pend);
                        m_busy     = 1'b0;
                    end
                end
                grant   = was_idle && aux_req && !vid_req;
                exp_gnt = grant;
                if (vid_req) exp_addr = vid_addr;
                else if (grant) exp_addr = aux_addr;
                if (grant) begin
                    m_busy = 1'b1; m_ret = RD_LAT; m_pend = aux_addr; m_waited = 0;
                end else if (was_idle && aux_req) begin
                    m_waited = m_waited + 1;
                end
                if (clr_stats) exp_starve = 1'b0;
                else if (m_waited >= STARVE_MAX) exp_starve = 1'b1;
                if (clr_stats) exp_cnt = '0;
                else if (grant && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_gnt",    32'(aux_gnt),     32'(exp_gnt));
            check("m_rvalid", 32'(aux_rvalid),  32'(exp_rvalid));
            check("m_rdata",  32'(aux_rdata),   32'(exp_rdata));
            check("m_addr",   32'(bram_addr),   32'(exp_addr));
            check("m_starve", 32'(aux_starve),  32'(exp_starve));
            check("m_cnt",    32'(aux_gnt_cnt), 32'(exp_cnt));
        end
    end

    task automatic wait_gnt(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!aux_gnt && k < 40);
        check(name, 32'(aux_gnt), 32'd1);
    endtask

    initial begin
        int gcount;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({aux_gnt, aux_rvalid, aux_starve}), 32'd0);
        rst_n = 1'b1;

        // Aux read in blanking
        @(negedge clk);
        aux_req = 1'b1; aux_addr = 17'd5120;
        wait_gnt("t3_gnt");
        check("t3_addr", 32'(bram_addr), 32'd5120);
        aux_req = 1'b0;
        @(negedge clk);
        check("t3_rv_early", 32'(aux_rvalid), 32'd0);
        @(negedge clk);
        check("t3_rvalid", 32'(aux_rvalid), 32'd1);
        check("t3_rdata", 32'(aux_rdata), 32'h1A5);

        // Video takes the port one cycle after an aux grant
        @(negedge clk);
        aux_req = 1'b1; aux_addr = 17'd9000;
        wait_gnt("t4_gnt");
        aux_req = 1'b0; vid_req = 1'b1; vid_addr = 17'd777;
        @(negedge clk);
        check("t4_addr1", 32'(bram_addr), 32'd777);
        check("t4_rv_early", 32'(aux_rvalid), 32'd0);
        vid_addr = 17'd778;
        @(negedge clk);
        check("t4_rvalid", 32'(aux_rvalid), 32'd1);
        check("t4_rdata", 32'(aux_rdata), 32'hF1D);
        check("t4_addr2", 32'(bram_addr), 32'd778);
        vid_req = 1'b0;

        // Video ramp with aux requesting throughout
        gcount = 0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (aux_gnt) gcount++;
            if (i > 0) check("t2_addr", 32'(bram_addr), 32'(i - 1));
            vid_req = 1'b1; vid_addr = AW'(i); aux_req = 1'b1; aux_addr = 17'd1234;
        end
        @(negedge clk);
        if (aux_gnt) gcount++;
        check("t2_addr_last", 32'(bram_addr), 32'd639);
        check("t2_no_gnt", 32'(gcount), 32'd0);
        check("t2_no_starve", 32'(aux_starve), 32'd0);

        // Starvation
        repeat (1024) @(negedge clk);
        check("t5_starve", 32'(aux_starve), 32'd1);
        vid_req = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_sticky", 32'(aux_starve), 32'd1);
        aux_req = 1'b0; clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check("t5_clr", 32'(aux_starve), 32'd0);
        check("t5_cnt_clr", 32'(aux_gnt_cnt), 32'd0);

        // Reset in the middle of an aux read
        @(negedge clk);
        aux_req = 1'b1; aux_addr = 17'd300;
        wait_gnt("t1_gnt");
        aux_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t1_rst_zero", 32'({aux_gnt, aux_rvalid, aux_starve}), 32'd0);
        check("t1_rst_addr", 32'(bram_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_no_rvalid", 32'(aux_rvalid), 32'd0);
        end
        aux_req = 1'b1; aux_addr = 17'd400;
        wait_gnt("t1_regnt");
        aux_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_rvalid", 32'(aux_rvalid), 32'd1);
        check("t1_rdata", 32'(aux_rdata), 32'hA55);

        // Random traffic, aux holds its request until granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vid_req   = ($urandom_range(0, 3) == 0);
            vid_addr  = AW'($urandom);
            clr_stats = ($urandom_range(0, 63) == 0);
            if (!aux_req || aux_gnt) begin
                aux_req  = 1'($urandom_range(0, 1));
                aux_addr = AW'($urandom);
            end
        end

        // Back-to-back grants until the counter saturates
        @(negedge clk);
        vid_req = 1'b0; clr_stats = 1'b0; aux_req = 1'b1; aux_addr = 17'd42;
        repeat (800) @(negedge clk);
        check("t6_sat", 32'(aux_gnt_cnt), 32'hFF);
        wait_gnt("t6_gnt");
        repeat (2) @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check("t6_clr_gnt", 32'(aux_gnt), 32'd1);
        check("t6_clr_wins", 32'(aux_gnt_cnt), 32'd0);
        repeat (3) @(negedge clk);
        check("t6_cnt_one", 32'(aux_gnt_cnt), 32'd1);
        aux_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
